// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
//
// Control FSM for the multicycle CPU. It decodes the 6-bit opcode held in
// the IR and steps each instruction through IF / ID / EXE / MEM / WB. In each
// state it drives the datapath write enables and mux selects.
//
// Ports:
//   CLK        in   1  rising-edge clock shared with PC / IR / register file
//   RST        in   1  synchronous, active-high reset
//   opcode     in   6  IR[31:26]
//   zero       in   1  ALU zero flag, used only in EXE_BR
//   state      out  3  current state encoding (debug)
//   PCWre      out  1  PC load enable
//   IRWre      out  1  IR load enable
//   InsMemRW   out  1  instruction-memory read (tied to 1)
//   RegWre     out  1  register-file write enable
//   DataMemRW  out  1  1 = data-memory write, 0 = read
//   ALUSrcB    out  1  1 = extended immediate, 0 = rt
//   ExtSel     out  1  1 = sign-extend, 0 = zero-extend
//   DBDataSrc  out  1  1 = memory data, 0 = ALU result
//   WrRegData  out  1  0 = PC+4 (jal), 1 = DB bus
//   RegDst     out  2  00 = $31, 01 = rt, 10 = rd
//   PCSrc      out  2  00 PC+4, 01 branch, 10 rs (jr), 11 jump target
//   ALUOp      out  3  000 add, 001 sub, 010 slt, 011 or, 100 and
// ---------------------------------------------------------------------------
module mc_control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic       DataMemRW,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic       WrRegData,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b011000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t r_state;
  state_t w_next_state;

  // Opcode class flags
  logic w_is_alu;    // add/sub/addi/or/and/ori/slt
  logic w_is_rtype;  // register-register ALU ops (write rd)
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_beq;
  logic w_is_j;
  logic w_is_jr;
  logic w_is_jal;
  logic w_is_halt;

  // ---------------------------------------------------------------------------
  // State register: the only sequential element.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IF;
    else     r_state <= w_next_state;
  end

  assign state    = r_state;
  assign InsMemRW = 1'b1;

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_is_alu   = 1'b0;
    w_is_rtype = 1'b0;
    w_is_lw    = 1'b0;
    w_is_sw    = 1'b0;
    w_is_beq   = 1'b0;
    w_is_j     = 1'b0;
    w_is_jr    = 1'b0;
    w_is_jal   = 1'b0;
    w_is_halt  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT: begin
        w_is_alu   = 1'b1;
        w_is_rtype = 1'b1;
      end
      OP_ADDI, OP_ORI: w_is_alu  = 1'b1;
      OP_LW:           w_is_lw   = 1'b1;
      OP_SW:           w_is_sw   = 1'b1;
      OP_BEQ:          w_is_beq  = 1'b1;
      OP_J:            w_is_j    = 1'b1;
      OP_JR:           w_is_jr   = 1'b1;
      OP_JAL:          w_is_jal  = 1'b1;
      OP_HALT:         w_is_halt = 1'b1;
      default: ;       // illegal: no class, executes as a 2-cycle nop
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = S_IF;
    case (r_state)
      S_IF: w_next_state = S_ID;
      S_ID: begin
        if (w_is_alu)                w_next_state = S_EXE_AL;
        else if (w_is_lw || w_is_sw) w_next_state = S_EXE_LS;
        else if (w_is_beq)           w_next_state = S_EXE_BR;
        else                         w_next_state = S_IF;  // j/jr/jal/halt/illegal
      end
      S_EXE_AL: w_next_state = S_WB_AL;
      S_WB_AL:  w_next_state = S_IF;
      S_EXE_LS: w_next_state = S_MEM;
      S_MEM:    w_next_state = w_is_lw ? S_WB_LD : S_IF;
      S_WB_LD:  w_next_state = S_IF;
      S_EXE_BR: w_next_state = S_IF;
      default:  w_next_state = S_IF;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: write enables and PC source depend on state; the remaining
  // selects depend only on opcode since the datapath ignores them elsewhere.
  // ---------------------------------------------------------------------------
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    DataMemRW = 1'b0;
    PCSrc     = 2'b00;

    case (r_state)
      S_IF: IRWre = 1'b1;
      S_ID: begin
        // Jumps and illegal opcodes finish here; halt finishes without
        // touching the PC so the same word is fetched again.
        if (!(w_is_alu || w_is_lw || w_is_sw || w_is_beq || w_is_halt))
          PCWre = 1'b1;
        if (w_is_j || w_is_jal) PCSrc = 2'b11;
        else if (w_is_jr)       PCSrc = 2'b10;
        if (w_is_jal)           RegWre = 1'b1;
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = zero ? 2'b01 : 2'b00;
      end
      S_WB_AL: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      S_MEM: begin
        if (w_is_sw) begin
          PCWre     = 1'b1;
          DataMemRW = 1'b1;
        end
      end
      S_WB_LD: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      default: ;
    endcase

    // Reset suppresses every write so an aborted instruction has no effect.
    if (RST) begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      DataMemRW = 1'b0;
    end
  end

  always_comb begin
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b1;
    DBDataSrc = 1'b0;
    WrRegData = 1'b1;
    RegDst    = 2'b00;
    ALUOp     = 3'b000;

    if (w_is_rtype)                                              RegDst = 2'b10;
    else if (opcode == OP_ADDI || opcode == OP_ORI || w_is_lw)   RegDst = 2'b01;

    if (opcode == OP_ADDI || opcode == OP_ORI || w_is_lw || w_is_sw)
      ALUSrcB = 1'b1;

    if (opcode == OP_ORI) ExtSel    = 1'b0;
    if (w_is_lw)          DBDataSrc = 1'b1;
    if (w_is_jal)         WrRegData = 1'b0;

    case (opcode)
      OP_SUB, OP_BEQ: ALUOp = 3'b001;
      OP_SLT:         ALUOp = 3'b010;
      OP_OR, OP_ORI:  ALUOp = 3'b011;
      OP_AND:         ALUOp = 3'b100;
      default:        ALUOp = 3'b000;  // add/addi/lw/sw and don't-care cases
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit
//
// Drives directed and random instruction streams into mc_control_unit and
// compares every cycle against a per-instruction reference model built from
// the opcode's state sequence and the datapath intent of each step.
// ---------------------------------------------------------------------------
module tb_mc_control_unit;

  logic       CLK;
  logic       RST;
  logic [5:0] opcode;
  logic       zero;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, RegWre, DataMemRW;
  logic       ALUSrcB, ExtSel, DBDataSrc, WrRegData;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [5:0] ADD  = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
  localparam logic [5:0] OR_  = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010;
  localparam logic [5:0] SLT  = 6'b011000, SW  = 6'b100110, LW   = 6'b100111;
  localparam logic [5:0] BEQ  = 6'b110000, J   = 6'b111000, JR   = 6'b111001;
  localparam logic [5:0] JAL  = 6'b111010, HALT = 6'b111111;

  logic [5:0] legal_ops [14] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLT,
                                 SW, LW, BEQ, J, JR, JAL, HALT};

  mc_control_unit dut (
    .CLK       (CLK),
    .RST       (RST),
    .opcode    (opcode),
    .zero      (zero),
    .state     (state),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .RegWre    (RegWre),
    .DataMemRW (DataMemRW),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .DBDataSrc (DBDataSrc),
    .WrRegData (WrRegData),
    .RegDst    (RegDst),
    .PCSrc     (PCSrc),
    .ALUOp     (ALUOp)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    for (int i = 0; i < 14; i++)
      if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_alu_op(input logic [5:0] op);
    return op inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLT};
  endfunction

  // Runs one instruction. zbr is the zero flag presented in the branch-execute
  // cycle; other cycles see a random zero. abort_at >= 0 raises RST in that
  // step of the instruction.
  task automatic run_instr(input logic [5:0] op, input logic zbr, input int abort_at);
    logic [2:0] seq[$];
    int         n;
    bit         last;
    logic [1:0] exp_pcsrc;
    bit         exp_regwre;

    // Visited states per instruction class.
    if (is_alu_op(op))  seq = '{3'd0, 3'd1, 3'd6, 3'd7};
    else if (op == LW)  seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    else if (op == SW)  seq = '{3'd0, 3'd1, 3'd2, 3'd3};
    else if (op == BEQ) seq = '{3'd0, 3'd1, 3'd5};
    else                seq = '{3'd0, 3'd1};
    n = seq.size();

    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      if (k == 0) opcode = op;
      last = (k == n - 1);
      zero = (seq[k] == 3'd5) ? zbr : 1'($urandom);

      if (k == abort_at) begin
        RST = 1'b1;
        #1;
        check("rst_state_hold", {29'd0, state}, {29'd0, seq[k]});
        check("rst_PCWre",      {31'd0, PCWre},     32'd0);
        check("rst_IRWre",      {31'd0, IRWre},     32'd0);
        check("rst_RegWre",     {31'd0, RegWre},    32'd0);
        check("rst_DataMemRW",  {31'd0, DataMemRW}, 32'd0);
        @(posedge CLK);
        #1;
        check("rst_edge_state", {29'd0, state}, 32'd0);
        RST = 1'b0;
        return;
      end

      #1;
      if (k == 1 && (op == J || op == JAL)) exp_pcsrc = 2'b11;
      else if (k == 1 && op == JR)          exp_pcsrc = 2'b10;
      else if (seq[k] == 3'd5)              exp_pcsrc = zbr ? 2'b01 : 2'b00;
      else                                  exp_pcsrc = 2'b00;
      exp_regwre = (last && (is_alu_op(op) || op == LW)) || (k == 1 && op == JAL);

      check("state",     {29'd0, state},     {29'd0, seq[k]});
      check("IRWre",     {31'd0, IRWre},     {31'd0, (k == 0)});
      check("PCWre",     {31'd0, PCWre},     {31'd0, (last && op != HALT)});
      check("RegWre",    {31'd0, RegWre},    {31'd0, exp_regwre});
      check("DataMemRW", {31'd0, DataMemRW}, {31'd0, (last && op == SW)});
      check("PCSrc",     {30'd0, PCSrc},     {30'd0, exp_pcsrc});
      check("InsMemRW",  {31'd0, InsMemRW},  32'd1);

      // Opcode-driven selects are meaningful once the opcode is stable.
      if (k >= 1) begin
        check("ALUSrcB",   {31'd0, ALUSrcB},   {31'd0, (op inside {ADDI, ORI, LW, SW})});
        check("ExtSel",    {31'd0, ExtSel},    {31'd0, (op != ORI)});
        check("DBDataSrc", {31'd0, DBDataSrc}, {31'd0, (op == LW)});
        check("WrRegData", {31'd0, WrRegData}, {31'd0, (op != JAL)});
        if (op inside {ADD, SUB, OR_, AND_, SLT}) check("RegDst", {30'd0, RegDst}, 32'd2);
        else if (op inside {ADDI, ORI, LW})       check("RegDst", {30'd0, RegDst}, 32'd1);
        else if (op == JAL)                       check("RegDst", {30'd0, RegDst}, 32'd0);
        if (op inside {ADD, ADDI, LW, SW})        check("ALUOp", {29'd0, ALUOp}, 32'd0);
        else if (op inside {SUB, BEQ})            check("ALUOp", {29'd0, ALUOp}, 32'd1);
        else if (op == SLT)                       check("ALUOp", {29'd0, ALUOp}, 32'd2);
        else if (op inside {OR_, ORI})            check("ALUOp", {29'd0, ALUOp}, 32'd3);
        else if (op == AND_)                      check("ALUOp", {29'd0, ALUOp}, 32'd4);
      end
    end
  endtask

  initial begin
    logic [5:0] op;
    int         n_st;

    RST    = 1'b1;
    opcode = 6'd0;
    zero   = 1'b0;

    // Reset held across several edges: state parks in IF, writes suppressed.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    check("init_state",     {29'd0, state},     32'd0);
    check("init_PCWre",     {31'd0, PCWre},     32'd0);
    check("init_IRWre",     {31'd0, IRWre},     32'd0);
    check("init_RegWre",    {31'd0, RegWre},    32'd0);
    check("init_DataMemRW", {31'd0, DataMemRW}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Directed sequence.
    run_instr(ADD,  1'b0, -1);
    run_instr(LW,   1'b0, -1);
    run_instr(SW,   1'b0, -1);
    run_instr(BEQ,  1'b1, -1);
    run_instr(BEQ,  1'b0, -1);
    run_instr(JAL,  1'b0, -1);
    run_instr(J,    1'b0, -1);
    run_instr(JR,   1'b0, -1);
    run_instr(6'b101010, 1'b0, -1);   // illegal
    repeat (4) run_instr(HALT, 1'b0, -1);
    run_instr(ADDI, 1'b0, 1);         // reset in ID aborts addi
    run_instr(ADDI, 1'b0, -1);

    // Random stream with occasional mid-instruction resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 85) begin
        op = legal_ops[$urandom_range(0, 13)];
      end else begin
        do op = 6'($urandom); while (is_legal(op));
      end
      if (is_alu_op(op) || op == SW) n_st = 4;
      else if (op == LW)             n_st = 5;
      else if (op == BEQ)            n_st = 3;
      else                           n_st = 2;
      if ($urandom_range(0, 11) == 0)
        run_instr(op, 1'($urandom), $urandom_range(0, n_st - 1));
      else
        run_instr(op, 1'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control FSM sequencing the PC register, instruction register, register file, ALU and data memory of the multicycle CPU. It decodes the 6-bit opcode latched in the IR and walks each instruction through IF/ID/EXE/MEM/WB states. In each state it drives the write enables (PCWre, IRWre, RegWre, DataMemRW) and the datapath mux selects. It sits beside the datapath at top level, on the same clock as the PC.

## Interface
- No parameters; opcode map fixed (see Operation).
- CLK  in  1  rising-edge clock shared with PC/IR/regfile.
- RST  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26].
- zero  in  1  ALU zero flag; sampled only in EXE_BR.
- state  out  3  current state encoding (debug).
- PCWre  out  1  PC load enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction memory read; constant 1.
- RegWre  out  1  register-file write enable.
- DataMemRW  out  1  1 = data-memory write, 0 = read.
- ALUSrcB  out  1  1 = extended immediate, 0 = rt.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- DBDataSrc  out  1  1 = memory data, 0 = ALU result.
- WrRegData  out  1  0 = PC+4 (jal), 1 = DB bus.
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs (jr), 11 = jump target.
- ALUOp  out  3  000 add, 001 sub, 010 slt (signed), 011 or, 100 and.

## Operation
- Opcodes:
  - add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, slt 011000 (ALU class).
  - sw 100110, lw 100111, beq 110000, j 111000, jr 111001, jal 111010, halt 111111.
  - Any other opcode is illegal.
- States: IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111.
- Transitions:
  - IF -> ID.
  - ID -> EXE_AL (ALU class), EXE_LS (lw/sw), EXE_BR (beq).
  - ID -> IF for j, jr, jal, halt and illegal opcodes.
  - EXE_AL -> WB_AL -> IF.
  - EXE_LS -> MEM.
  - MEM -> WB_LD for lw, MEM -> IF for sw.
  - WB_LD -> IF.
  - EXE_BR -> IF.
- State register is the only sequential element. All outputs decode combinationally from state and opcode.
- IRWre = 1 only in IF.
- PCWre = 1 only in the last state of each instruction:
  - ID for j/jr/jal/illegal.
  - EXE_BR, WB_AL, MEM (sw), WB_LD.
  - Never for halt.
- PCSrc:
  - 11 for j/jal in ID; 10 for jr in ID.
  - In EXE_BR: 01 if zero=1, else 00.
  - 00 everywhere else.
- RegWre = 1 in WB_AL, in WB_LD, and in ID for jal (RegDst=00, WrRegData=0). Otherwise 0.
- RegDst: 10 for R-type (add/sub/or/and/slt); 01 for addi/ori/lw; 00 for jal.
- ALUSrcB = 1 for addi/ori/lw/sw.
- ExtSel = 0 only for ori.
- DBDataSrc = 1 only for lw. WrRegData = 1 except jal.
- ALUOp:
  - add/addi/lw/sw -> 000.
  - sub/beq -> 001.
  - slt -> 010.
  - or/ori -> 011.
  - and -> 100.
- DataMemRW = 1 only in MEM with sw.
- halt: the PC is never written, so the FSM re-fetches the same instruction in an IF/ID loop until reset.
- Illegal opcode: behaves as a nop (PC+4, no register or memory write).

## Timing
- Reset:
  - RST high at a rising edge -> state = IF on that edge.
  - While RST is high, PCWre, IRWre, RegWre and DataMemRW are forced to 0. Mux selects are don't-care.
  - Reset mid-instruction aborts it. No write occurs in the reset cycle.
- Cycles per instruction:
  - j/jr/jal/halt/illegal: 2.
  - beq: 3.
  - ALU class and sw: 4.
  - lw: 5.
- After reset deassertion, the first edge performs IF (the IR loads). The PC advances on the final edge of each instruction.
- zero must be valid within the EXE_BR cycle. It is ignored in all other states.
- Opcode is stable from the edge after IF until the next IF.

## Test plan
- Reset, then add (000000) with RST held low:
  - state sequence 000,001,110,111,000.
  - PCWre = 1 only in state 111; RegWre = 1 and RegDst = 10 in 111; IRWre = 1 only in 000.
- lw (100111):
  - sequence 000,001,010,011,100.
  - DataMemRW = 0 throughout; in 100: RegWre = 1, DBDataSrc = 1, RegDst = 01, PCWre = 1.
- sw (100110):
  - sequence 000,001,010,011,000.
  - In 011: DataMemRW = 1, PCWre = 1; RegWre = 0 in every state.
- beq (110000):
  - with zero = 1 in EXE_BR -> PCSrc = 01, PCWre = 1.
  - repeat with zero = 0 -> PCSrc = 00; ALUOp = 001 in both cases.
- jal (111010):
  - in ID: PCSrc = 11, RegWre = 1, RegDst = 00, WrRegData = 0, PCWre = 1; next state 000.
- halt (111111), then RST pulsed in state 001 during an addi:
  - halt: states alternate 000/001 with PCWre = 0 forever.
  - addi reset mid-instruction: state = 000 on the reset edge, with no RegWre pulse.
